cmd_scheduler: RTL and testbench

- Queues bottom-half commands and issues them one at a time to a command executor.
- Each command is a 4-bit number plus a post-command settle delay in microseconds.
- Owns the shared delay timer (24 clocks/us) so that executors no longer load a delay counter themselves.
- Sits between the data-write decode and the osc-clocked command processing; replaces ad-hoc run/finish toggling with a valid/ack handshake.

---
 rtl/cmd_sched_pkg.sv | 34 +++
 rtl/cmd_sched_fifo.sv | 75 +++++++
 rtl/cmd_scheduler.sv | 136 +++++++++++++
 tb/tb_cmd_scheduler.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_sched_pkg.sv
// Shared types, widths and the settle-delay arithmetic for the command scheduler.
package cmd_sched_pkg;

    localparam int unsigned CMD_W          = 4;
    localparam int unsigned DLY_W          = 12;
    localparam int unsigned CNT_W          = 16;
    localparam int unsigned DEF_CLK_PER_US = 24;
    localparam int unsigned DEF_MAX_US     = 2730;

    // One queued command: {cmd, delay_us}.
    typedef struct packed {
        logic [CMD_W-1:0] cmd;
        logic [DLY_W-1:0] delay_us;
    } entry_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StExec  = 2'd1,
        StDelay = 2'd2
    } state_t;

    // Settle time in osc cycles; the clamp keeps the product inside 16 bits.
    function automatic logic [CNT_W-1:0] settle_cycles(input logic [DLY_W-1:0] dly_us,
                                                       input int unsigned     clk_per_us,
                                                       input int unsigned     max_us);
        int unsigned us;
        us = 32'(dly_us);
        if (us > max_us) begin
            us = max_us;
        end
        return CNT_W'(us * clk_per_us);
    endfunction

endpackage

// File: rtl/cmd_sched_fifo.sv
// Circular command queue with level count, empty flag and a registered ready (not full).
module cmd_sched_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [Width-1:0]           i_data,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output logic [Width-1:0]           o_data,
    output logic [$clog2(Depth+1)-1:0] o_level,
    output logic                       o_empty,
    output logic                       o_ready
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned LvlW = $clog2(Depth+1);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr_ptr, w_wr_ptr_d;
    logic [PtrW-1:0]  r_rd_ptr, w_rd_ptr_d;
    logic [LvlW-1:0]  r_level, w_level_d;
    logic             r_ready;

    // Next pointers and level; flush discards everything, including a same-cycle push/pop.
    always_comb begin
        w_wr_ptr_d = r_wr_ptr;
        w_rd_ptr_d = r_rd_ptr;
        w_level_d  = r_level;
        if (i_flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_level_d  = '0;
        end else begin
            // Depth is a power of two, so pointers wrap naturally.
            if (i_push) w_wr_ptr_d = r_wr_ptr + 1'b1;
            if (i_pop)  w_rd_ptr_d = r_rd_ptr + 1'b1;
            unique case ({i_push, i_pop})
                2'b10:   w_level_d = r_level + 1'b1;
                2'b01:   w_level_d = r_level - 1'b1;
                default: w_level_d = r_level;
            endcase
        end
    end

    // Pointer, level and ready registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ready  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_d;
            r_rd_ptr <= w_rd_ptr_d;
            r_level  <= w_level_d;
            r_ready  <= (w_level_d != LvlW'(Depth));
        end
    end

    // Entry storage; contents need no reset since level guards every read.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_level = r_level;
    assign o_empty = (r_level == '0);
    assign o_ready = r_ready;

endmodule

// File: rtl/cmd_scheduler.sv
// Issues queued commands one at a time over a valid/ack handshake and owns the settle timer.
module cmd_scheduler
    import cmd_sched_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CLK_PER_US = DEF_CLK_PER_US,
    parameter int unsigned MAX_US     = DEF_MAX_US
) (
    input  logic                       __osc,
    input  logic                       __rst_n,
    input  logic                       push_valid,
    input  logic [CMD_W-1:0]           push_cmd,
    input  logic [DLY_W-1:0]           push_delay_us,
    output logic                       push_ready,
    input  logic                       flush,
    output logic                       exec_valid,
    output logic [CMD_W-1:0]           exec_cmd,
    input  logic                       exec_ack,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       overflow
);

    state_t           r_state, w_state_d;
    logic             r_exec_valid, w_exec_valid_d;
    logic [CMD_W-1:0] r_exec_cmd, w_exec_cmd_d;
    logic [CNT_W-1:0] r_dly_cyc, w_dly_cyc_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic             r_flushed, w_flushed_d;
    logic             r_overflow, w_overflow_d;

    logic             w_push;
    logic             w_pop;
    logic             w_ack;
    logic             w_empty;
    entry_t           w_head;
    entry_t           w_push_entry;

    assign w_push_entry = '{cmd: push_cmd, delay_us: push_delay_us};
    assign w_push       = push_valid && push_ready && !flush;

    cmd_sched_fifo #(
        .Depth (DEPTH),
        .Width ($bits(entry_t))
    ) u_fifo (
        .i_clk   (__osc),
        .i_rst_n (__rst_n),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (flush),
        .o_data  (w_head),
        .o_level (level),
        .o_empty (w_empty),
        .o_ready (push_ready)
    );

    // An ack only counts once the command is actually on offer.
    assign w_ack = exec_ack && r_exec_valid;

    // Next state, pop decision, handshake and settle-timer control.
    always_comb begin
        w_state_d      = r_state;
        w_exec_valid_d = r_exec_valid;
        w_exec_cmd_d   = r_exec_cmd;
        w_dly_cyc_d    = r_dly_cyc;
        w_cnt_d        = r_cnt;
        w_flushed_d    = r_flushed;
        w_pop          = 1'b0;
        w_overflow_d   = flush ? 1'b0 : (r_overflow || (push_valid && !push_ready));
        case (r_state)
            StIdle: begin
                if (!w_empty && !flush) begin
                    w_pop        = 1'b1;
                    w_exec_cmd_d = w_head.cmd;
                    w_dly_cyc_d  = settle_cycles(w_head.delay_us, CLK_PER_US, MAX_US);
                    w_flushed_d  = 1'b0;
                    w_state_d    = StExec;
                end
            end
            StExec: begin
                // The executor cannot be aborted; a flush only cancels the settle delay.
                w_exec_valid_d = 1'b1;
                if (flush) w_flushed_d = 1'b1;
                if (w_ack) begin
                    w_exec_valid_d = 1'b0;
                    if (r_flushed || flush || (r_dly_cyc == '0)) begin
                        w_state_d = StIdle;
                    end else begin
                        w_cnt_d   = r_dly_cyc - 1'b1;
                        w_state_d = StDelay;
                    end
                end
            end
            StDelay: begin
                if (flush || (r_cnt == '0)) begin
                    w_cnt_d   = '0;
                    w_state_d = StIdle;
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_d      = StIdle;
                w_exec_valid_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge __osc) begin
        if (!__rst_n) begin
            r_state      <= StIdle;
            r_exec_valid <= 1'b0;
            r_exec_cmd   <= '0;
            r_dly_cyc    <= '0;
            r_cnt        <= '0;
            r_flushed    <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_exec_valid <= w_exec_valid_d;
            r_exec_cmd   <= w_exec_cmd_d;
            r_dly_cyc    <= w_dly_cyc_d;
            r_cnt        <= w_cnt_d;
            r_flushed    <= w_flushed_d;
            r_overflow   <= w_overflow_d;
        end
    end

    assign exec_valid = r_exec_valid;
    assign exec_cmd   = r_exec_cmd;
    assign overflow   = r_overflow;
    assign busy       = (r_state != StIdle) || !w_empty;

endmodule

// File: tb/tb_cmd_scheduler.sv
// Scoreboard bench for cmd_scheduler: issued commands are checked in push order.
module tb_cmd_scheduler;

    logic        osc;
    logic        rst_n;
    logic        push_valid;
    logic [3:0]  push_cmd;
    logic [11:0] push_delay_us;
    logic        push_ready;
    logic        flush;
    logic        exec_valid;
    logic [3:0]  exec_cmd;
    logic        exec_ack;
    logic        busy;
    logic [2:0]  level;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    int rises = 0;
    int sb[$];
    logic prev_valid = 1'b0;

    cmd_scheduler #(
        .DEPTH      (4),
        .CLK_PER_US (24),
        .MAX_US     (2730)
    ) dut (
        .__osc         (osc),
        .__rst_n       (rst_n),
        .push_valid    (push_valid),
        .push_cmd      (push_cmd),
        .push_delay_us (push_delay_us),
        .push_ready    (push_ready),
        .flush         (flush),
        .exec_valid    (exec_valid),
        .exec_cmd      (exec_cmd),
        .exec_ack      (exec_ack),
        .busy          (busy),
        .level         (level),
        .overflow      (overflow)
    );

    initial osc = 1'b0;
    always #5 osc = ~osc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge osc);
        #1;
    endtask

    task automatic push(input int cmd, input int dly, input bit accepted);
        push_valid    = 1'b1;
        push_cmd      = cmd[3:0];
        push_delay_us = dly[11:0];
        if (accepted) sb.push_back(cmd);
        cyc();
        push_valid = 1'b0;
    endtask

    task automatic wait_valid(input int bound);
        int n = 0;
        while (!exec_valid && n < bound) begin
            cyc();
            n++;
        end
        if (!exec_valid) check_eq("valid_timeout", 0, 1);
    endtask

    task automatic ack();
        exec_ack = 1'b1;
        cyc();
        exec_ack = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_valid"}, exec_valid, 0);
        check_eq({tag, "_cmd"}, exec_cmd, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_level"}, level, 0);
        check_eq({tag, "_ovf"}, overflow, 0);
        check_eq({tag, "_ready"}, push_ready, 1);
    endtask

    // Push, ack at once, then count settle cycles while busy; compares to min(d,2730)*24.
    task automatic measure_delay(input int cmd, input int dly);
        int n = 0;
        int exp_cyc;
        bit valid_seen = 1'b0;
        exp_cyc = ((dly > 2730) ? 2730 : dly) * 24;
        push(cmd, dly, 1'b1);
        wait_valid(10);
        ack();
        while (busy && n < 70000) begin
            if (exec_valid) valid_seen = 1'b1;
            cyc();
            n++;
        end
        check_eq($sformatf("delay_cycles_%0d", dly), n, exp_cyc);
        check_eq($sformatf("delay_novalid_%0d", dly), valid_seen, 0);
    endtask

    // Scoreboard: every new offer must carry the oldest outstanding command.
    always @(negedge osc) begin
        if (rst_n && exec_valid && !prev_valid) begin
            rises++;
            if (sb.size() == 0) begin
                check_eq("exec_unexpected", exec_cmd, 32'hffff_ffff);
            end else begin
                check_eq("exec_cmd_order", exec_cmd, sb.pop_front());
            end
        end
        prev_valid = exec_valid;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int r0;
        rst_n = 1'b0; push_valid = 1'b0; push_cmd = '0; push_delay_us = '0;
        flush = 1'b0; exec_ack = 1'b0;
        cyc();
        cyc();
        check_reset_vals("rst");
        rst_n = 1'b1;
        cyc();

        // Single command, zero delay: valid two edges after the push.
        push(3, 0, 1'b1);
        check_eq("t0_level", level, 1);
        check_eq("t0_valid", exec_valid, 0);
        cyc();
        check_eq("t1_valid", exec_valid, 0);
        cyc();
        check_eq("t2_valid", exec_valid, 1);
        check_eq("t2_cmd", exec_cmd, 3);
        repeat (4) cyc();
        check_eq("pre_ack_busy", busy, 1);
        ack();
        check_eq("ack_valid", exec_valid, 0);
        check_eq("ack_busy", busy, 0);

        // Settle timing, including the clamp.
        measure_delay(1, 10);
        measure_delay(7, 1);
        measure_delay(2, 4000);

        // Fill to DEPTH with one in flight, then overflow.
        push(4, 0, 1'b1);
        push(5, 0, 1'b1);
        push(6, 0, 1'b1);
        push(7, 0, 1'b1);
        push(8, 0, 1'b1);
        check_eq("full_level", level, 4);
        check_eq("full_ready", push_ready, 0);
        check_eq("full_ovf", overflow, 0);
        push(9, 0, 1'b0);
        check_eq("drop_ovf", overflow, 1);
        check_eq("drop_level", level, 4);
        for (int k = 0; k < 5; k++) begin
            wait_valid(10);
            ack();
        end
        check_eq("drain_busy", busy, 0);
        check_eq("drain_sb", sb.size(), 0);

        // Flush in DELAY with two queued; a same-cycle push is dropped.
        push(10, 5, 1'b1);
        push(11, 0, 1'b1);
        push(12, 0, 1'b1);
        wait_valid(10);
        ack();
        repeat (3) cyc();
        check_eq("fd_level", level, 2);
        check_eq("fd_busy", busy, 1);
        check_eq("fd_ovf_sticky", overflow, 1);
        flush = 1'b1; push_valid = 1'b1; push_cmd = 4'd15; push_delay_us = '0;
        cyc();
        flush = 1'b0; push_valid = 1'b0;
        sb.delete();
        check_eq("fd_busy_after", busy, 0);
        check_eq("fd_level_after", level, 0);
        check_eq("fd_ovf_after", overflow, 0);
        check_eq("fd_ready_after", push_ready, 1);
        r0 = rises;
        repeat (10) cyc();
        check_eq("fd_no_issue", rises, r0);

        // Flush in EXEC while full and overflowed.
        push(13, 7, 1'b1);
        push(1, 0, 1'b1);
        push(2, 0, 1'b1);
        push(3, 0, 1'b1);
        push(4, 0, 1'b1);
        push(5, 0, 1'b0);
        check_eq("fe_ovf", overflow, 1);
        wait_valid(10);
        check_eq("fe_cmd", exec_cmd, 13);
        flush = 1'b1; push_valid = 1'b1; push_cmd = 4'd6; push_delay_us = '0;
        cyc();
        flush = 1'b0; push_valid = 1'b0;
        sb.delete();
        check_eq("fe_level", level, 0);
        check_eq("fe_ovf_cleared", overflow, 0);
        check_eq("fe_valid_held", exec_valid, 1);
        repeat (3) cyc();
        check_eq("fe_valid_still", exec_valid, 1);
        check_eq("fe_cmd_still", exec_cmd, 13);
        ack();
        check_eq("fe_ack_valid", exec_valid, 0);
        check_eq("fe_ack_busy", busy, 0);
        repeat (5) cyc();
        check_eq("fe_no_delay", busy, 0);

        // Reset during EXEC with three queued; a late ack is ignored.
        push(1, 3, 1'b1);
        push(2, 0, 1'b1);
        push(3, 0, 1'b1);
        push(4, 0, 1'b1);
        wait_valid(10);
        check_eq("rm_level", level, 3);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        sb.delete();
        check_reset_vals("rm");
        r0 = rises;
        ack();
        check_eq("late_ack_valid", exec_valid, 0);
        check_eq("late_ack_busy", busy, 0);
        repeat (10) cyc();
        check_eq("rm_no_issue", rises, r0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
